para_hit: RTL and testbench
===========================

Name: para_hit

Overview:
Hit detector for the para channel. It consumes the averaged para sample stream together with the threshold and dwell configuration from the para register bank (cfg_th, cfg_hdt, cfg_ldt). It declares a hit when the signal stays at or above threshold for a qualifying time. It counts re-crossings ("ring") inside each event and returns stu_hit_id and stu_ring to the register bank for readback.

Parameters:
D_W, 16, sample and threshold width
T_W, 32, dwell counter and dwell config width
C_W, 16, hit and ring counter width

Ports:
clk_sys  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
data_vld  in  1  one-cycle strobe, data_in valid
data_in  in  D_W  averaged para sample, unsigned
cfg_th  in  D_W  hit threshold, unsigned
cfg_hdt  in  T_W  high dwell, in clk_sys cycles
cfg_ldt  in  T_W  low dwell, in clk_sys cycles
stu_clr  in  1  synchronous clear of stu_hit_id and stu_ring
hit_pulse  out  1  one-cycle strobe on hit declaration
hit_active  out  1  high while in HIT or HOLD
stu_hit_id  out  C_W  hits since reset/clear, wraps
stu_ring  out  C_W  ring count of last completed event
stu_hit_ts  out  T_W  timestamp of last hit (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; dur_cnt 0; ring_cnt 0; above_r 0.
- above_r: updates only on data_vld to (data_in >= cfg_th), unsigned compare. It holds between strobes. The FSM acts on above_r every clk_sys cycle.
- Effective dwell: hdt_e = max(cfg_hdt,1); ldt_e = max(cfg_ldt,1). Compare with >= so live config changes take effect on the next cycle.
- dur_cnt saturates at all-ones.
- IDLE:
  - above_r=1 and hdt_e=1 -> HIT directly, with declare actions.
  - above_r=1 otherwise -> QUAL, dur_cnt=1.
- QUAL:
  - above_r=0 -> IDLE, dur_cnt=0.
  - else if dur_cnt+1 >= hdt_e -> HIT, with declare actions.
  - else dur_cnt++.
- Declare actions, registered with the transition: hit_pulse=1 for exactly one cycle; stu_hit_id++ (wraps to 0); ring_cnt=1; dur_cnt=0.
- HIT:
  - above_r=0 and ldt_e=1 -> IDLE, with close actions.
  - above_r=0 otherwise -> HOLD, dur_cnt=1.
- HOLD:
  - above_r=1 -> HIT; ring_cnt++ saturating at all-ones; dur_cnt=0.
  - else if dur_cnt+1 >= ldt_e -> IDLE, with close actions.
  - else dur_cnt++.
- Close actions: stu_ring=ring_cnt; ring_cnt=0.
- hit_active = (state==HIT || state==HOLD), registered-state decode.
- Latency:
  - data_vld sample -> above_r: 1 cycle.
  - Hit declared hdt_e cycles after above_r rises; hit_pulse asserts in the same cycle as state HIT.
- stu_clr: zeroes stu_hit_id and stu_ring the next cycle. It does not disturb FSM or ring_cnt.
- stu_clr coincident with a declare: stu_hit_id=1.
- stu_clr coincident with a close: stu_ring=ring_cnt (event wins).
- Reset mid-event: immediate return to IDLE, no partial stu_ring update.

Optional Feature:
- Macro PARA_HIT_TS_EN.
- Defined:
  - Free-running T_W counter from reset, wrapping.
  - stu_hit_ts latches the counter value in the hit_pulse cycle.
  - stu_clr zeroes stu_hit_ts.
- Undefined: no counter is built; stu_hit_ts tied to 0.

Decomposition:
- Package para_pkg: FSM state encoding (IDLE=0, QUAL=1, HIT=2, HOLD=3); D_W/T_W/C_W defaults.
- Sub-module para_dur_cnt: saturating T_W counter with clr/inc and a ">= limit" flag, where limit = max(cfg,1).
  - One instance serves QUAL and HOLD, which are mutually exclusive.
  - The FSM, ring/hit counters and timestamp stay in para_hit.

Test Plan:
- cfg_th=0xA000, cfg_hdt=5, cfg_ldt=10; data 0xA000 held with data_vld every cycle -> above_r rises; hit_pulse exactly once, 5 cycles after above_r rises; stu_hit_id=1; hit_active=1.
- Same config; above for 3 cycles, then 0x9FFF -> no hit_pulse; state back to IDLE; stu_hit_id unchanged.
- After a hit: below for 4 cycles, above, below 4, above, then below for 10 -> stu_ring=3 at close; hit_active falls; stu_hit_id still 1.
- cfg_hdt=0 and cfg_ldt=0; single above sample followed by a below sample -> hit_pulse in the cycle after above_r rises; IDLE the cycle after above_r falls; stu_ring=1.
- stu_clr asserted in the same cycle as a hit declaration -> stu_hit_id=1 and stu_ring=0 on the next cycle; with PARA_HIT_TS_EN, stu_hit_ts equals the counter value in the hit_pulse cycle.
- rst_n pulsed low while in HOLD -> all outputs 0 asynchronously; a subsequent event counts from stu_hit_id=1.

Source files
------------

// File: rtl/para_pkg.sv
// para_pkg: shared widths and FSM state encoding for the para hit detector.
package para_pkg;
    localparam int D_W_DEF = 16;
    localparam int T_W_DEF = 32;
    localparam int C_W_DEF = 16;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_QUAL = 2'd1;
    localparam logic [1:0] ST_HIT  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;
endpackage

// File: rtl/para_dur_cnt.sv
// para_dur_cnt: saturating dwell counter; o_ge flags that the next count reaches max(i_cfg,1).
module para_dur_cnt
    import para_pkg::*;
#(
    parameter int T_W = T_W_DEF
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    input  logic           i_clr,
    input  logic           i_inc,
    input  logic [T_W-1:0] i_cfg,
    output logic           o_ge
);
    logic [T_W-1:0] r_cnt;
    logic [T_W-1:0] w_lim;
    assign w_lim = (i_cfg == '0) ? T_W'(1) : i_cfg;
    // one extra bit so a saturated count plus one cannot wrap
    assign o_ge = ({1'b0, r_cnt} + (T_W+1)'(1)) >= {1'b0, w_lim};
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && !(&r_cnt))
            r_cnt <= r_cnt + T_W'(1);
    end
endmodule

// File: rtl/para_hit.sv
// para_hit: para channel hit detector with dwell qualification and ring counting.
// Define PARA_HIT_TS_EN to build the free-running timestamp behind stu_hit_ts.
module para_hit
    import para_pkg::*;
#(
    parameter int D_W = D_W_DEF,
    parameter int T_W = T_W_DEF,
    parameter int C_W = C_W_DEF
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    input  logic           data_vld,
    input  logic [D_W-1:0] data_in,
    input  logic [D_W-1:0] cfg_th,
    input  logic [T_W-1:0] cfg_hdt,
    input  logic [T_W-1:0] cfg_ldt,
    input  logic           stu_clr,
    output logic           hit_pulse,
    output logic           hit_active,
    output logic [C_W-1:0] stu_hit_id,
    output logic [C_W-1:0] stu_ring,
    output logic [T_W-1:0] stu_hit_ts
);
    logic [1:0]     r_state;
    logic [1:0]     w_nxt;
    logic           r_above;
    logic [C_W-1:0] r_ring;
    logic           w_lo_side;
    logic           w_ge;
    logic           w_declare;
    logic           w_close;
    logic           w_ring_up;

    // IDLE/QUAL qualify against the high dwell, HIT/HOLD against the low dwell
    assign w_lo_side = ~r_state[1];
    assign w_nxt = w_lo_side ? (!r_above ? ST_IDLE : (w_ge ? ST_HIT : ST_QUAL))
                             : ( r_above ? ST_HIT  : (w_ge ? ST_IDLE : ST_HOLD));
    assign w_declare = w_lo_side & r_above & w_ge;
    assign w_close   = ~w_lo_side & ~r_above & w_ge;
    assign w_ring_up = (r_state == ST_HOLD) & r_above;
    assign hit_active = r_state[1];

    // dwell is zero on entry to IDLE and HIT, so w_ge there means "dwell of one"
    para_dur_cnt #(.T_W(T_W)) u_dur (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .i_clr   (~w_nxt[0]),
        .i_inc   (w_nxt[0]),
        .i_cfg   (w_lo_side ? cfg_hdt : cfg_ldt),
        .o_ge    (w_ge)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_above    <= 1'b0;
            r_ring     <= '0;
            hit_pulse  <= 1'b0;
            stu_hit_id <= '0;
            stu_ring   <= '0;
        end else begin
            r_state   <= w_nxt;
            hit_pulse <= w_declare;
            if (data_vld)
                r_above <= (data_in >= cfg_th);
            if (w_declare)
                r_ring <= C_W'(1);
            else if (w_close)
                r_ring <= '0;
            else if (w_ring_up && !(&r_ring))
                r_ring <= r_ring + C_W'(1);
            if (w_declare)
                stu_hit_id <= stu_clr ? C_W'(1) : stu_hit_id + C_W'(1);
            else if (stu_clr)
                stu_hit_id <= '0;
            if (w_close)
                stu_ring <= r_ring;
            else if (stu_clr)
                stu_ring <= '0;
        end
    end

`ifdef PARA_HIT_TS_EN
    logic [T_W-1:0] r_ts;
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_ts       <= '0;
            stu_hit_ts <= '0;
        end else begin
            r_ts <= r_ts + T_W'(1);
            if (hit_pulse)
                stu_hit_ts <= r_ts;
            else if (stu_clr)
                stu_hit_ts <= '0;
        end
    end
`else
    assign stu_hit_ts = '0;
`endif
endmodule

// File: tb/tb_para_hit.sv
// tb_para_hit: directed stimulus against a run-length model of the hit detector.
module tb_para_hit;
    localparam int D_W = 16;
    localparam int T_W = 32;
    localparam int C_W = 16;
`ifdef PARA_HIT_TS_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic           clk_sys = 1'b0;
    logic           rst_n = 1'b0;
    logic           data_vld = 1'b0;
    logic           stu_clr = 1'b0;
    logic [D_W-1:0] data_in = '0;
    logic [D_W-1:0] cfg_th = 16'hA000;
    logic [T_W-1:0] cfg_hdt = 32'd5;
    logic [T_W-1:0] cfg_ldt = 32'd10;
    logic           hit_pulse;
    logic           hit_active;
    logic [C_W-1:0] stu_hit_id;
    logic [C_W-1:0] stu_ring;
    logic [T_W-1:0] stu_hit_ts;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pulse = 0;

    // model: above flag, run lengths of the current high/low stretch, event flag
    bit             m_a, m_in_ev, m_pulse;
    longint         m_hi_run, m_lo_run;
    logic [C_W-1:0] m_id, m_sring, m_ring;
    logic [T_W-1:0] m_ts_cnt, m_ts;

    para_hit #(.D_W(D_W), .T_W(T_W), .C_W(C_W)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .data_vld   (data_vld),
        .data_in    (data_in),
        .cfg_th     (cfg_th),
        .cfg_hdt    (cfg_hdt),
        .cfg_ldt    (cfg_ldt),
        .stu_clr    (stu_clr),
        .hit_pulse  (hit_pulse),
        .hit_active (hit_active),
        .stu_hit_id (stu_hit_id),
        .stu_ring   (stu_ring),
        .stu_hit_ts (stu_hit_ts)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_in_ev = 0; m_pulse = 0;
        m_hi_run = 0; m_lo_run = 0;
        m_id = '0; m_sring = '0; m_ring = '0;
        m_ts_cnt = '0; m_ts = '0;
    endtask

    task automatic model_update();
        longint hdt_e, ldt_e;
        bit dec, cls;
        if (!rst_n) begin
            model_reset();
        end else begin
            hdt_e = (cfg_hdt == 0) ? 64'd1 : longint'(cfg_hdt);
            ldt_e = (cfg_ldt == 0) ? 64'd1 : longint'(cfg_ldt);
            if (m_pulse) m_ts = m_ts_cnt;
            else if (stu_clr) m_ts = '0;
            m_ts_cnt = m_ts_cnt + 1;
            if (m_a) begin m_hi_run++; m_lo_run = 0; end
            else begin m_lo_run++; m_hi_run = 0; end
            dec = 0; cls = 0;
            if (!m_in_ev) dec = m_a && (m_hi_run >= hdt_e);
            else begin
                if (m_a && m_hi_run == 1 && m_ring != '1) m_ring = m_ring + 1;
                cls = !m_a && (m_lo_run >= ldt_e);
            end
            m_pulse = dec;
            if (dec) begin
                m_in_ev = 1; m_ring = 1;
                m_id = stu_clr ? C_W'(1) : m_id + 1;
            end else if (stu_clr) m_id = '0;
            if (cls) begin
                m_in_ev = 0; m_sring = m_ring; m_ring = '0;
            end else if (stu_clr) m_sring = '0;
            if (data_vld) m_a = (data_in >= cfg_th);
        end
    endtask

    task automatic compare_all();
        if (hit_pulse === 1'b1) n_pulse++;
        chk("hit_pulse", 64'(hit_pulse), 64'(m_pulse));
        chk("hit_active", 64'(hit_active), 64'(m_in_ev));
        chk("stu_hit_id", 64'(stu_hit_id), 64'(m_id));
        chk("stu_ring", 64'(stu_ring), 64'(m_sring));
        chk("stu_hit_ts", 64'(stu_hit_ts), TS_EN ? 64'(m_ts) : 64'd0);
    endtask

    // called at a negedge: drive, clock, advance model, sample at next negedge
    task automatic step(input logic v, input logic [D_W-1:0] d, input logic c);
        data_vld = v; data_in = d; stu_clr = c;
        @(posedge clk_sys);
        model_update();
        @(negedge clk_sys);
        compare_all();
    endtask

    initial begin
        int pulse_step;
        model_reset();
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        compare_all();
        chk("reset_id", 64'(stu_hit_id), 64'd0);
        rst_n = 1'b1;

        // sustained threshold-level input: hit on the 6th edge (1 for above_r + 5 dwell)
        pulse_step = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 16'hA000, 1'b0);
            if (hit_pulse === 1'b1 && pulse_step == 0) pulse_step = i;
        end
        chk("lit_pulse_step", 64'(pulse_step), 64'd6);
        chk("lit_pulse_cnt1", 64'(n_pulse), 64'd1);
        chk("lit_id1", 64'(stu_hit_id), 64'd1);
        chk("lit_active1", 64'(hit_active), 64'd1);

        // two re-crossings inside the event, then a long low closes it
        repeat (4) step(1'b1, 16'h0000, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);
        repeat (4) step(1'b1, 16'h1234, 1'b0);
        step(1'b1, 16'hA001, 1'b0);
        repeat (14) step(1'b1, 16'h9FFF, 1'b0);
        chk("lit_ring3", 64'(stu_ring), 64'd3);
        chk("lit_active_fall", 64'(hit_active), 64'd0);
        chk("lit_id_still1", 64'(stu_hit_id), 64'd1);

        // short excursion does not qualify
        repeat (3) step(1'b1, 16'hA000, 1'b0);
        repeat (6) step(1'b1, 16'h9FFF, 1'b0);
        chk("lit_nohit_cnt", 64'(n_pulse), 64'd1);
        chk("lit_nohit_id", 64'(stu_hit_id), 64'd1);
        chk("lit_nohit_active", 64'(hit_active), 64'd0);

        // zero dwell config behaves as one cycle
        cfg_hdt = 0; cfg_ldt = 0;
        step(1'b1, 16'hC000, 1'b0);
        step(1'b1, 16'h0001, 1'b0);
        chk("lit_zd_pulse", 64'(hit_pulse), 64'd1);
        step(1'b0, 16'h0000, 1'b0);
        chk("lit_zd_closed", 64'(hit_active), 64'd0);
        chk("lit_zd_ring", 64'(stu_ring), 64'd1);
        chk("lit_zd_id", 64'(stu_hit_id), 64'd2);
        repeat (2) step(1'b0, 16'h0000, 1'b0);

        // clear coincident with a declaration
        step(1'b1, 16'hA000, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        chk("lit_clr_id", 64'(stu_hit_id), 64'd1);
        chk("lit_clr_ring", 64'(stu_ring), 64'd0);
        step(1'b1, 16'h0000, 1'b0);
        repeat (3) step(1'b0, 16'h0000, 1'b0);
        chk("lit_clr_close_ring", 64'(stu_ring), 64'd1);

        // asynchronous reset while in HOLD
        cfg_hdt = 1; cfg_ldt = 10;
        step(1'b1, 16'hA000, 1'b0);
        step(1'b1, 16'h0000, 1'b0);
        repeat (3) step(1'b0, 16'h0000, 1'b0);
        chk("lit_hold_active", 64'(hit_active), 64'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("lit_rst_active", 64'(hit_active), 64'd0);
        chk("lit_rst_id", 64'(stu_hit_id), 64'd0);
        chk("lit_rst_ring", 64'(stu_ring), 64'd0);
        chk("lit_rst_ts", 64'(stu_hit_ts), 64'd0);
        @(negedge clk_sys);
        step(1'b0, 16'h0000, 1'b0);
        rst_n = 1'b1;
        cfg_hdt = 5;
        repeat (8) step(1'b1, 16'hB000, 1'b0);
        chk("lit_post_rst_id", 64'(stu_hit_id), 64'd1);
        chk("lit_post_rst_active", 64'(hit_active), 64'd1);
        repeat (12) step(1'b1, 16'h0000, 1'b0);
        chk("lit_post_rst_ring", 64'(stu_ring), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
